// File: rtl/ex_fwd_hazard_unit.sv
// EX-stage operand forwarding and load-use hazard controller for the 5-stage MIPS core.
// Tracks EX/MEM destination registers and registers the operand mux selects for the next cycle.
module ex_fwd_hazard_unit #(
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic              id_imm_b,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic [REG_AW-1:0] id_dst,
    input  logic              flush,
    output logic              stall,
    output logic [1:0]        ex_fwd_a_sel,
    output logic [1:0]        ex_fwd_b_sel,
    output logic              ex_valid
);

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_EX  = 2'b01;
    localparam logic [1:0] SEL_MEM = 2'b10;
    localparam logic [1:0] SEL_IMM = 2'b11;

    logic [REG_AW-1:0] ex_dst_reg;
    logic              ex_rw_reg;
    logic              ex_ld_reg;
    logic              ex_valid_reg;
    logic [REG_AW-1:0] mem_dst_reg;
    logic              mem_rw_reg;
    logic [1:0]        a_sel_reg;
    logic [1:0]        b_sel_reg;

    // Index 0 is operand A (rs), index 1 is operand B (rt).
    logic [REG_AW-1:0] src [2];
    logic [1:0]        src_used;
    logic [1:0]        hit_ex;
    logic [1:0]        hit_mem;
    logic [1:0][1:0]   sel_next;
    logic [1:0]        b_sel_next;
    logic              bubble;

    assign src[0]      = id_rs;
    assign src[1]      = id_rt;
    assign src_used[0] = id_uses_rs;
    assign src_used[1] = id_uses_rt & ~id_imm_b;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            assign hit_ex[gi]  = ex_rw_reg & ex_valid_reg & (ex_dst_reg == src[gi])
                                 & (src[gi] != '0);
            assign hit_mem[gi] = mem_rw_reg & (mem_dst_reg == src[gi]) & (src[gi] != '0);
            // The EX occupant is the younger producer, so it takes priority over MEM.
            assign sel_next[gi] = !src_used[gi] ? SEL_RF  :
                                  hit_ex[gi]    ? SEL_EX  :
                                  hit_mem[gi]   ? SEL_MEM : SEL_RF;
        end
    endgenerate

    assign b_sel_next = id_imm_b ? SEL_IMM : sel_next[1];

    // A load in EX cannot forward its data until it reaches MEM.
    assign stall  = id_valid & ~flush & ex_ld_reg & ex_valid_reg & (|(src_used & hit_ex));
    assign bubble = stall | flush | ~id_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_dst_reg   <= '0;
            ex_rw_reg    <= 1'b0;
            ex_ld_reg    <= 1'b0;
            ex_valid_reg <= 1'b0;
            mem_dst_reg  <= '0;
            mem_rw_reg   <= 1'b0;
            a_sel_reg    <= SEL_RF;
            b_sel_reg    <= SEL_RF;
        end else begin
            mem_dst_reg <= ex_dst_reg;
            mem_rw_reg  <= ex_rw_reg & ex_valid_reg;
            if (bubble) begin
                ex_valid_reg <= 1'b0;
                ex_rw_reg    <= 1'b0;
                ex_ld_reg    <= 1'b0;
                a_sel_reg    <= SEL_RF;
                b_sel_reg    <= SEL_RF;
            end else begin
                ex_valid_reg <= 1'b1;
                ex_rw_reg    <= id_regwrite;
                ex_ld_reg    <= id_memread;
                ex_dst_reg   <= id_dst;
                a_sel_reg    <= sel_next[0];
                b_sel_reg    <= b_sel_next;
            end
        end
    end

    assign ex_fwd_a_sel = a_sel_reg;
    assign ex_fwd_b_sel = b_sel_reg;
    assign ex_valid     = ex_valid_reg;

endmodule

// File: tb/tb_ex_fwd_hazard_unit.sv
// Bench for ex_fwd_hazard_unit: instruction-history model checked every cycle,
// plus directed instruction sequences with hand-computed expectations.
module tb_ex_fwd_hazard_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_uses_rs;
    logic       id_uses_rt;
    logic       id_imm_b;
    logic       id_regwrite;
    logic       id_memread;
    logic [4:0] id_dst;
    logic       flush;
    logic       stall;
    logic [1:0] ex_fwd_a_sel;
    logic [1:0] ex_fwd_b_sel;
    logic       ex_valid;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    ex_fwd_hazard_unit #(.REG_AW(5)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_imm_b(id_imm_b),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .id_dst(id_dst),
        .flush(flush), .stall(stall), .ex_fwd_a_sel(ex_fwd_a_sel),
        .ex_fwd_b_sel(ex_fwd_b_sel), .ex_valid(ex_valid)
    );

    always #5 clk = ~clk;

    // Model: the instruction records currently sitting in EX and MEM.
    typedef struct {
        bit       valid;
        bit       writes;
        bit       load;
        bit [4:0] dst;
        bit [1:0] a;
        bit [1:0] b;
    } instr_t;

    instr_t in_ex  = '{default: 0};
    instr_t in_mem = '{default: 0};

    // 1 = newest writer of r is in EX, 2 = in MEM, 0 = none (or r is $0).
    function automatic int producer(input bit [4:0] r);
        if (r == 0) return 0;
        if (in_ex.valid && in_ex.writes && in_ex.dst == r) return 1;
        if (in_mem.valid && in_mem.writes && in_mem.dst == r) return 2;
        return 0;
    endfunction

    function automatic bit [1:0] want_sel(input bit used, input bit [4:0] r);
        if (!used) return 2'd0;
        return 2'(producer(r));
    endfunction

    function automatic bit model_stall();
        bit dep;
        dep = (id_uses_rs && producer(id_rs) == 1) ||
              (id_uses_rt && !id_imm_b && producer(id_rt) == 1);
        return id_valid && !flush && in_ex.valid && in_ex.load && dep;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            in_ex  = '{default: 0};
            in_mem = '{default: 0};
        end else begin
            instr_t nxt;
            nxt = '{default: 0};
            if (id_valid && !flush && !model_stall()) begin
                nxt.valid  = 1;
                nxt.writes = id_regwrite;
                nxt.load   = id_memread;
                nxt.dst    = id_dst;
                nxt.a      = want_sel(id_uses_rs, id_rs);
                nxt.b      = id_imm_b ? 2'd3 : want_sel(id_uses_rt, id_rt);
            end
            in_mem = in_ex;
            in_ex  = nxt;
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_stall", 8'(stall), 8'(model_stall()));
            chk("model_valid", 8'(ex_valid), 8'(in_ex.valid));
            chk("model_a_sel", 8'(ex_fwd_a_sel), 8'(in_ex.a));
            chk("model_b_sel", 8'(ex_fwd_b_sel), 8'(in_ex.b));
        end
    end

    task automatic put(input bit v, input bit [4:0] rs, input bit [4:0] rt, input bit urs,
                       input bit urt, input bit imm, input bit rw, input bit ld,
                       input bit [4:0] dst, input bit fl);
        id_valid = v; id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
        id_imm_b = imm; id_regwrite = rw; id_memread = ld; id_dst = dst; flush = fl;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        put(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        step();
    endtask

    task automatic show(input string name);
        $display("%s: stall=%0b valid=%0b a=%0b b=%0b", name, stall, ex_valid,
                 ex_fwd_a_sel, ex_fwd_b_sel);
    endtask

    initial begin
        rst = 1'b1;
        put(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        step();
        rst = 1'b0;
        cmp_en = 1'b1;
        chk("reset_valid", 8'(ex_valid), 8'd0);
        chk("reset_a", 8'(ex_fwd_a_sel), 8'd0);
        chk("reset_b", 8'(ex_fwd_b_sel), 8'd0);
        chk("reset_stall", 8'(stall), 8'd0);
        show("reset");

        // add $3,$1,$2 ; sub $4,$3,$5
        drain();
        put(1, 1, 2, 1, 1, 0, 1, 0, 3, 0); #1 chk("b2b_add_stall", 8'(stall), 8'd0);
        step();
        put(1, 3, 5, 1, 1, 0, 1, 0, 4, 0); #1 chk("b2b_sub_stall", 8'(stall), 8'd0);
        step();
        chk("b2b_a", 8'(ex_fwd_a_sel), 8'd1);
        chk("b2b_b", 8'(ex_fwd_b_sel), 8'd0);
        chk("b2b_valid", 8'(ex_valid), 8'd1);
        show("back_to_back");

        // add $3 ; nop ; or $6,$7,$3
        drain();
        put(1, 1, 2, 1, 1, 0, 1, 0, 3, 0); step();
        put(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); step();
        put(1, 7, 3, 1, 1, 0, 1, 0, 6, 0); step();
        chk("dist2_a", 8'(ex_fwd_a_sel), 8'd0);
        chk("dist2_b", 8'(ex_fwd_b_sel), 8'd2);
        show("distance_2");

        // add $3 ; add $3 ; and $8,$3,$3
        drain();
        put(1, 1, 2, 1, 1, 0, 1, 0, 3, 0); step();
        put(1, 4, 5, 1, 1, 0, 1, 0, 3, 0); step();
        put(1, 3, 3, 1, 1, 0, 1, 0, 8, 0); step();
        chk("double_a", 8'(ex_fwd_a_sel), 8'd1);
        chk("double_b", 8'(ex_fwd_b_sel), 8'd1);
        show("double_producer");

        // lw $2,0($1) ; add $4,$2,$2
        drain();
        put(1, 1, 0, 1, 0, 1, 1, 1, 2, 0); step();
        put(1, 2, 2, 1, 1, 0, 1, 0, 4, 0); #1 chk("lu_stall", 8'(stall), 8'd1);
        step();
        chk("lu_bubble_valid", 8'(ex_valid), 8'd0);
        chk("lu_stall_once", 8'(stall), 8'd0);
        step();
        chk("lu_a", 8'(ex_fwd_a_sel), 8'd2);
        chk("lu_b", 8'(ex_fwd_b_sel), 8'd2);
        chk("lu_valid", 8'(ex_valid), 8'd1);
        show("load_use");

        // add $0,$1,$2 ; addi $5,$0,7 ; lw $0 ; add $4,$0,$0
        drain();
        put(1, 1, 2, 1, 1, 0, 1, 0, 0, 0); step();
        put(1, 0, 0, 1, 0, 1, 1, 0, 5, 0); #1 chk("zero_addi_stall", 8'(stall), 8'd0);
        step();
        chk("zero_a", 8'(ex_fwd_a_sel), 8'd0);
        chk("imm_b", 8'(ex_fwd_b_sel), 8'd3);
        put(1, 1, 0, 1, 0, 1, 1, 1, 0, 0); step();
        put(1, 0, 0, 1, 1, 0, 1, 0, 4, 0); #1 chk("zero_lw_stall", 8'(stall), 8'd0);
        step();
        chk("zero_lw_a", 8'(ex_fwd_a_sel), 8'd0);
        chk("zero_lw_b", 8'(ex_fwd_b_sel), 8'd0);
        show("zero_and_imm");

        // lw $2 ; add using $2 with flush
        drain();
        put(1, 1, 0, 1, 0, 1, 1, 1, 2, 0); step();
        put(1, 2, 2, 1, 1, 0, 1, 0, 4, 1); #1 chk("flush_stall", 8'(stall), 8'd0);
        step();
        chk("flush_valid", 8'(ex_valid), 8'd0);
        show("flush");

        // add $3 ; reset edge ; sub $4,$3,$5
        drain();
        put(1, 1, 2, 1, 1, 0, 1, 0, 3, 0); step();
        put(1, 3, 5, 1, 1, 0, 1, 0, 4, 0);
        rst = 1'b1;
        step();
        chk("rst_valid", 8'(ex_valid), 8'd0);
        chk("rst_a", 8'(ex_fwd_a_sel), 8'd0);
        chk("rst_b", 8'(ex_fwd_b_sel), 8'd0);
        chk("rst_stall", 8'(stall), 8'd0);
        rst = 1'b0;
        step();
        chk("rst_consumer_a", 8'(ex_fwd_a_sel), 8'd0);
        chk("rst_consumer_valid", 8'(ex_valid), 8'd1);
        show("reset_mid");

        // Mixed vectors over a small register set, checked by the model each cycle.
        for (int i = 0; i < 300; i++) begin
            put($urandom_range(0, 7) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                1'($urandom), 1'($urandom), $urandom_range(0, 3) == 0, 1'($urandom),
                $urandom_range(0, 2) == 0, 5'($urandom_range(0, 3)),
                $urandom_range(0, 9) == 0);
            rst = ($urandom_range(0, 40) == 0);
            step();
        end
        rst = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_fwd_hazard_unit.md
# ex_fwd_hazard_unit

Pipelined forwarding and load-use hazard controller for the 5-stage MIPS core. Tracks the destination register of the instructions occupying EX and MEM, compares them against the source registers of the instruction in ID, and produces registered select codes that drive the two EX-stage 4:1 operand multiplexers (ALU input A and B) during the following cycle. Also raises the IF/ID stall and inserts an EX bubble on a load-use dependency.

## Interface
Parameters:
- REG_AW, default 5: register-address width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- id_valid  in  1  ID holds a real instruction
- id_rs  in  REG_AW  source A register
- id_rt  in  REG_AW  source B register
- id_uses_rs  in  1  instruction reads rs
- id_uses_rt  in  1  instruction reads rt as an ALU operand
- id_imm_b  in  1  ALU operand B is the immediate
- id_regwrite  in  1  instruction writes a register
- id_memread  in  1  instruction is a load
- id_dst  in  REG_AW  destination register
- flush  in  1  kill the ID instruction (taken branch or jump)
- stall  out  1  combinational; hold PC and IF/ID, bubble EX next cycle
- ex_fwd_a_sel  out  2  registered operand-A mux select
- ex_fwd_b_sel  out  2  registered operand-B mux select
- ex_valid  out  1  registered; EX holds a real instruction

## Operation
- Select encoding, matching the mux inputs in1..in4:
  - 00: register-file read data.
  - 01: EX/MEM ALU result.
  - 10: MEM/WB write-back data.
  - 11: immediate. Used only for B; A never takes 11.
- Internal tracking registers:
  - EX occupant: ex_dst, ex_rw, ex_ld.
  - MEM occupant: mem_dst, mem_rw.
- Match conditions, evaluated on ID sources each cycle:
  - matchEX(r) = ex_rw & ex_valid & (ex_dst == r) & (r != 0).
  - matchMEM(r) = mem_rw & (mem_dst == r) & (r != 0).
- Next A select, priority order:
  - 00 if !id_uses_rs.
  - 01 if matchEX(rs). This is the youngest producer and wins.
  - 10 if matchMEM(rs).
  - 00 otherwise.
- Next B select: 11 if id_imm_b. Otherwise the same rules as A using rt, gated by id_uses_rt.
- Load-use stall:
  - stall = id_valid & !flush & ex_ld & ex_valid & ((id_uses_rs & matchEX(rs)) | (id_uses_rt & !id_imm_b & matchEX(rt))).
- Advance on every rising clk edge without rst:
  - MEM tracking takes the EX tracking values: mem_rw <= ex_rw & ex_valid.
  - If stall or flush or !id_valid, EX takes a bubble: ex_valid=0, ex_rw=0, ex_ld=0, both sels=00.
  - Otherwise EX takes the ID values and the computed selects.
- After a stall the load has moved to MEM, so re-evaluation of the held ID instruction yields select 10 with no second stall.
- A write to $0 is never forwarded and never causes a stall.

## Timing
- Selects are computed in ID and registered, so they are valid throughout the cycle the instruction is in EX. Latency is 1 cycle.
- stall is combinational from the ID inputs and the EX tracking registers, and is valid within the same cycle.
- A stall always lasts exactly 1 cycle per load-use pair.
- Reset: ex_valid=0, ex_rw=0, ex_ld=0, mem_rw=0, dsts=0, both sels=00. stall is therefore 0 in the first cycle after reset.
- rst asserted mid-operation overrides stall and flush. All tracking registers clear on that edge, and in-flight producers are forgotten.
- flush and stall together: flush wins. stall=0 and EX takes a bubble.
- The same register matching both EX and MEM selects 01.
- rs == rt with both matching produces identical A and B selects.

## Test plan
- Back-to-back dependency: add $3,$1,$2 then sub $4,$3,$5 -> during sub's EX cycle, ex_fwd_a_sel=01, ex_fwd_b_sel=00, stall never asserted.
- Distance-2 dependency: add $3 ; nop ; or $6,$7,$3 -> during or's EX, ex_fwd_b_sel=10, a_sel=00.
- Double producer: add $3 ; add $3 ; and $8,$3,$3 -> a_sel=b_sel=01, the younger producer wins.
- Load-use: lw $2,0($1) then add $4,$2,$2 -> stall=1 for exactly one cycle and ex_valid=0 in the next cycle. When add enters EX: a_sel=b_sel=10.
- Zero register and immediate: add $0,... then addi $5,$0,7 -> a_sel=00, b_sel=11, no stall even when the producer is a lw to $0.
- Flush and reset:
  - lw $2 ; add using $2 with flush=1 -> stall=0 and EX bubble.
  - Assert rst for one edge between a producer and a consumer -> the consumer gets sel 00 and all outputs read 0 after that edge.
